// File: rtl/bounce_emulator_if.sv
// -----------------------------------------------------------------------------
// bounce_emulator_if
// Command handshake and status bundle for the contact-bounce emulator.
//
// Signals:
//   cmd_valid   request to drive bounce_out to cmd_level
//   cmd_level   target level of the request
//   cmd_ready   emulator idle; accept = cmd_valid & cmd_ready
//   bounce_out  emulated raw button line (registered)
//   busy        sequence in progress
//   settled     one-cycle pulse when a sequence completes
//
// Modports:
//   master  the requester (self-test sequencer / testbench)
//   slave   the emulator
// -----------------------------------------------------------------------------
interface bounce_emulator_if;
    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;
    logic bounce_out;
    logic busy;
    logic settled;

    modport master (
        output cmd_valid,
        output cmd_level,
        input  cmd_ready,
        input  bounce_out,
        input  busy,
        input  settled
    );

    modport slave (
        input  cmd_valid,
        input  cmd_level,
        output cmd_ready,
        output bounce_out,
        output busy,
        output settled
    );
endinterface

// File: rtl/bounce_emulator.sv
// -----------------------------------------------------------------------------
// bounce_emulator
// Turns a clean level command into a contact-bounce waveform: an immediate
// edge to the target, an even number of pseudo-random away/back bounces,
// a clean settle period, then a one-cycle settled pulse.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bif       bounce_emulator_if.slave (cmd_valid/cmd_level in,
//             cmd_ready/bounce_out/busy/settled out)
//
// Parameters:
//   TICK_DIV      clk cycles per tick (2..255)
//   BOUNCE_MAX    max away/back bounce pairs (0..15)
//   SETTLE_TICKS  ticks held at target before settled (1..255)
//   SEED          LFSR reset value (8'h00 is replaced by 8'h01)
//   IDLE_LEVEL    bounce_out after reset
//
// Build option:
//   BOUNCE_DETERMINISTIC_EN  when defined, the LFSR is bypassed: pairs is
//                            always BOUNCE_MAX and every segment is one tick.
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// BOUNCE| toggling bounce_out at segment ends until toggles_left is 0
// SETTLE| bounce_out held at target, counting down the settle ticks
// -----------------------------------------------------------------------------
module bounce_emulator #(
    parameter int unsigned TICK_DIV     = 5,
    parameter int unsigned BOUNCE_MAX   = 4,
    parameter int unsigned SETTLE_TICKS = 20,
    parameter logic [7:0]  SEED         = 8'hA5,
    parameter logic        IDLE_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    bounce_emulator_if.slave  bif
);

    localparam logic [7:0] LFSR_INIT   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] DIV_LAST    = 8'(TICK_DIV - 1);
    localparam logic [3:0] PAIRS_MAX   = 4'(BOUNCE_MAX);
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t     r_state,  w_state_nxt;
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;
    logic [7:0] r_div;
    logic       w_tick;
    logic       w_accept;
    logic       r_bounce_out, w_bounce_nxt;
    logic       r_settled,    w_settled_nxt;
    logic [4:0] r_toggles,    w_toggles_nxt;
    logic [3:0] r_seg,        w_seg_nxt;
    logic [7:0] r_settle_cnt, w_settle_nxt;
    logic [3:0] w_pairs;
    logic [3:0] w_seg_load;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so widths depend on
    // when the command arrives.
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_INIT;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_accept = bif.cmd_valid && (r_state == S_IDLE);
    assign w_tick   = (r_div == DIV_LAST);

    // Clearing on accept puts the first tick TICK_DIV cycles after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 8'd0;
        end else if (w_accept || w_tick) begin
            r_div <= 8'd0;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

`ifdef BOUNCE_DETERMINISTIC_EN
    assign w_pairs    = PAIRS_MAX;
    assign w_seg_load = 4'd1;
`else
    assign w_pairs    = (r_lfsr[7:4] > PAIRS_MAX) ? PAIRS_MAX : r_lfsr[7:4];
    assign w_seg_load = {1'b0, r_lfsr[2:0]} + 4'd1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bounce_out <= IDLE_LEVEL;
            r_settled    <= 1'b0;
            r_toggles    <= 5'd0;
            r_seg        <= 4'd0;
            r_settle_cnt <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_bounce_out <= w_bounce_nxt;
            r_settled    <= w_settled_nxt;
            r_toggles    <= w_toggles_nxt;
            r_seg        <= w_seg_nxt;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bounce_nxt  = r_bounce_out;
        w_settled_nxt = 1'b0;
        w_toggles_nxt = r_toggles;
        w_seg_nxt     = r_seg;
        w_settle_nxt  = r_settle_cnt;

        case (r_state)
            S_IDLE: begin
                if (bif.cmd_valid) begin
                    if (bif.cmd_level == r_bounce_out) begin
                        w_state_nxt  = S_SETTLE;
                        w_settle_nxt = SETTLE_INIT;
                    end else begin
                        w_bounce_nxt  = bif.cmd_level;
                        // Even toggle count lands back on the target level.
                        w_toggles_nxt = {w_pairs, 1'b0};
                        w_seg_nxt     = w_seg_load;
                        w_state_nxt   = S_BOUNCE;
                    end
                end
            end

            S_BOUNCE: begin
                if (w_tick) begin
                    if (r_seg == 4'd1) begin
                        if (r_toggles != 5'd0) begin
                            w_bounce_nxt  = ~r_bounce_out;
                            w_toggles_nxt = r_toggles - 5'd1;
                            w_seg_nxt     = w_seg_load;
                        end else begin
                            w_state_nxt  = S_SETTLE;
                            w_settle_nxt = SETTLE_INIT;
                        end
                    end else begin
                        w_seg_nxt = r_seg - 4'd1;
                    end
                end
            end

            S_SETTLE: begin
                if (w_tick) begin
                    if (r_settle_cnt == 8'd1) begin
                        w_settled_nxt = 1'b1;
                        w_settle_nxt  = 8'd0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_settle_nxt = r_settle_cnt - 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bif.bounce_out = r_bounce_out;
    assign bif.settled    = r_settled;
    assign bif.busy       = (r_state != S_IDLE);
    assign bif.cmd_ready  = (r_state == S_IDLE);

endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
- Converts a clean level command into a realistic contact-bounce waveform on a single output line.
- Used for on-board self-test of the reaction timer: the emulated raw button is muxed into the debouncer input in place of the physical pin.
- Bounce count and segment widths are pseudo-random from an internal LFSR. A clean settle period follows the bounces, then a done pulse.

Parameters:
- TICK_DIV, 5, clk cycles per bounce time unit (tick); range 2..255
- BOUNCE_MAX, 4, max number of away/back bounce pairs; range 0..15
- SETTLE_TICKS, 20, ticks output is held stable at target before done; range 1..255
- SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01
- IDLE_LEVEL, 0, bounce_out value after reset

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  request to drive bounce_out to cmd_level
- cmd_level  input  1  target level of request
- cmd_ready  output  1  high in IDLE; accept = cmd_valid & cmd_ready
- bounce_out  output  1  emulated raw button line (registered)
- busy  output  1  high in BOUNCE or SETTLE
- settled  output  1  one-cycle pulse when sequence completes

Behaviour:
- Reset (async, reset_n=0): state IDLE, bounce_out=IDLE_LEVEL, settled=0, busy=0, cmd_ready=1, LFSR=SEED, all counters 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts every clk cycle regardless of state.
- Tick: divider counts 0..TICK_DIV-1 and is cleared on accept. Tick is asserted on the cycle the count equals TICK_DIV-1. The first tick occurs TICK_DIV cycles after the accept edge.
- States: IDLE, BOUNCE, SETTLE.
- IDLE, accept with cmd_level == bounce_out: no toggling. Go directly to SETTLE with full SETTLE_TICKS.
- IDLE, accept with cmd_level != bounce_out:
  - On the accept edge, bounce_out <= cmd_level.
  - pairs = min(lfsr[7:4], BOUNCE_MAX); toggles_left <= 2*pairs.
  - seg <= lfsr[2:0]+1 ticks; state BOUNCE.
- BOUNCE: each tick decrements seg. When seg==1 at a tick:
  - if toggles_left>0: invert bounce_out, decrement toggles_left, reload seg <= lfsr[2:0]+1.
  - else: state SETTLE, settle counter <= SETTLE_TICKS.
- An even toggle count guarantees bounce_out == target on entry to SETTLE.
- SETTLE: bounce_out constant. Each tick decrements the counter. At the tick where counter==1:
  - settled=1 for exactly one cycle;
  - state IDLE on the same edge, so cmd_ready=1 in the same cycle as settled.
- cmd_valid outside IDLE is ignored: no queueing, no effect on the running sequence.
- busy = (state != IDLE); cmd_ready = (state == IDLE).
- Segment widths are 1..8 ticks; total sequence length ≤ 8*(2*BOUNCE_MAX+1)+SETTLE_TICKS ticks.
- Reset asserted mid-sequence: immediate return to reset values. No settled pulse for the aborted command.
- BOUNCE_MAX=0: no bounces. Single clean edge, then settle.

Optional Feature:
- Macro: BOUNCE_DETERMINISTIC_EN.
- Defined: LFSR outputs are bypassed. pairs = BOUNCE_MAX; every segment is exactly 1 tick. Waveform is fully predictable for regression.
- Undefined: pseudo-random pairs and segment widths as above.

Test Plan:
- Deterministic, defaults (TICK_DIV=5, BOUNCE_MAX=4, SETTLE_TICKS=20):
  - Stimulus: accept cmd_level=1 at edge k, from reset.
  - Required bounce_out: 1@k, 0@k+5, 1@k+10, 0@k+15, 1@k+20, 0@k+25, 1@k+30, 0@k+35, 1@k+40.
  - SETTLE entered @k+45; settled pulse and cmd_ready=1 @k+145; busy high k+1..k+145.
- Deterministic: accept cmd_level=0 while bounce_out=0 -> no toggles; settled pulse 100 cycles after accept.
- Deterministic: mid-sequence, cmd_valid=1 with cmd_level=0 @k+12 -> ignored; waveform identical to first scenario.
- Deterministic: reset_n low @k+22 -> bounce_out=0, busy=0, cmd_ready=1 asynchronously; no settled pulse afterwards.
- Random, 200 alternating commands:
  - Each toggle count is even and ≤ 8.
  - Each segment is 5..40 cycles.
  - Final level equals cmd_level for ≥100 cycles before each settled pulse.
  - Exactly one settled pulse per accept.
- Deterministic, BOUNCE_MAX=0: accept 1 -> single rise at accept edge; settled pulse 105 cycles later.
